// File: rtl/cache_controller.sv
// cache_controller: miss-handling FSM for a direct-mapped write-back data cache
module cache_controller #(
  parameter int TAG_W    = 25,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 4,
  parameter int BLOCK_W  = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        address,
  input  logic [7:0]         writedata,
  output logic               busywait,
  input  logic               mem_BusyWait,
  input  logic [TAG_W-1:0]   Tag1,
  input  logic [BLOCK_W-1:0] writedata1,
  input  logic [TAG_W-1:0]   Tag,
  input  logic [INDEX_W-1:0] Index,
  input  logic               hit,
  input  logic               dirty,
  output logic               mem_Read,
  output logic               mem_Write,
  output logic [BLOCK_W-1:0] mem_Writedata,
  output logic [31:0]        mem_Address
);
  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ} state_t;
  state_t state, next_state;
  logic issued;
  logic [TAG_W-1:0] tag_l, tag1_l;
  logic [INDEX_W-1:0] index_l;
  logic [BLOCK_W-1:0] block_l;
  logic miss, done;
  logic unused_inputs;
  assign unused_inputs = ^{address, writedata};
  assign miss = (read | write) & ~hit;
  // issued blocks an exit on a busy line memory has not yet had time to raise
  assign done = issued & ~mem_BusyWait;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      issued  <= 1'b0;
      tag_l   <= '0;
      tag1_l  <= '0;
      index_l <= '0;
      block_l <= '0;
    end else begin
      state  <= next_state;
      issued <= (state != IDLE) && (next_state == state);
      if (state == IDLE && next_state != IDLE) begin
        tag_l   <= Tag;
        tag1_l  <= Tag1;
        index_l <= Index;
        block_l <= writedata1;
      end
    end
  end
  always_comb begin
    next_state    = state;
    busywait      = 1'b1;
    mem_Read      = 1'b0;
    mem_Write     = 1'b0;
    mem_Address   = '0;
    mem_Writedata = '0;
    case (state)
      IDLE: begin
        busywait = miss;
        if (miss) next_state = dirty ? WRITE_BACK : MEM_READ;
      end
      WRITE_BACK: begin
        mem_Write     = 1'b1;
        mem_Address   = {tag1_l, index_l, {OFFSET_W{1'b0}}};
        mem_Writedata = block_l;
        if (done) next_state = MEM_READ;
      end
      MEM_READ: begin
        mem_Read    = 1'b1;
        mem_Address = {tag_l, index_l, {OFFSET_W{1'b0}}};
        if (done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed vectors, corner sequences and a transfer-queue reference model
module tb_cache_controller;
  logic clock = 1'b0;
  logic reset, read, write, mem_BusyWait, hit, dirty;
  logic busywait, mem_Read, mem_Write;
  logic [31:0] address, mem_Address;
  logic [7:0] writedata;
  logic [24:0] Tag1, Tag;
  logic [2:0] Index;
  logic [127:0] writedata1, mem_Writedata;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cache_controller dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .busywait(busywait),
    .mem_BusyWait(mem_BusyWait), .Tag1(Tag1), .writedata1(writedata1),
    .Tag(Tag), .Index(Index), .hit(hit), .dirty(dirty),
    .mem_Read(mem_Read), .mem_Write(mem_Write),
    .mem_Writedata(mem_Writedata), .mem_Address(mem_Address)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string name, input logic [2:0] ef, input logic [31:0] ea, input logic [127:0] ed);
    check({name, " busywait"}, 128'(busywait), 128'(ef[2]));
    check({name, " mem_Read"}, 128'(mem_Read), 128'(ef[1]));
    check({name, " mem_Write"}, 128'(mem_Write), 128'(ef[0]));
    check({name, " mem_Address"}, 128'(mem_Address), 128'(ea));
    check({name, " mem_Writedata"}, mem_Writedata, ed);
  endtask

  // in_f = {reset, read, write, hit, dirty, mem_BusyWait}; exp_f = {busywait, mem_Read, mem_Write}
  typedef struct {
    logic [5:0] in_f;
    logic [24:0] tag, tag1;
    logic [2:0] idx;
    logic [127:0] wd1;
    logic [2:0] exp_f;
    logic [31:0] e_addr;
    logic [127:0] e_wd;
  } vec_t;
  vec_t tv[$];

  function automatic void add(input logic [5:0] f, input logic [24:0] tg, input logic [2:0] ix,
                              input logic [24:0] t1, input logic [127:0] w1,
                              input logic [2:0] ef, input logic [31:0] ea, input logic [127:0] ed);
    vec_t v;
    v.in_f = f; v.tag = tg; v.idx = ix; v.tag1 = t1; v.wd1 = w1;
    v.exp_f = ef; v.e_addr = ea; v.e_wd = ed;
    tv.push_back(v);
  endfunction

  // reference model: a miss queues a write-back (if dirty) then a fetch; each takes >=2 edges
  typedef struct {logic wr; logic [31:0] addr; logic [127:0] data;} xfer_t;
  xfer_t mq[$];
  int dwell;

  task automatic model_edge();
    if (!reset) begin
      mq.delete();
      dwell = 0;
    end else if (mq.size() == 0) begin
      if ((read | write) && !hit) begin
        if (dirty) mq.push_back('{1'b1, {Tag1, Index, 4'h0}, writedata1});
        mq.push_back('{1'b0, {Tag, Index, 4'h0}, 128'h0});
        dwell = 0;
      end
    end else if (dwell > 0 && !mem_BusyWait) begin
      void'(mq.pop_front());
      dwell = 0;
    end else dwell++;
  endtask

  localparam logic [127:0] BLK = 128'hDEADBEEF_0BADF00D_CAFEBABE_01234567;
  localparam logic [127:0] Z = 128'h0;

  initial begin
    int hi;
    reset = 1'b0; read = 1'b0; write = 1'b0; mem_BusyWait = 1'b0; hit = 1'b0; dirty = 1'b0;
    address = 32'h0; writedata = 8'h0; Tag1 = '0; Tag = '0; Index = '0; writedata1 = '0;
    @(posedge clock); #1;
    // reset held with a pending miss
    add(6'b010000, 25'h0, 3'd0, 25'h0, Z, 3'b100, 32'h0, Z);
    add(6'b010000, 25'h0, 3'd0, 25'h0, Z, 3'b100, 32'h0, Z);
    add(6'b100000, 25'h0, 3'd0, 25'h0, Z, 3'b000, 32'h0, Z);
    // read hits
    for (int i = 0; i < 5; i++) add(6'b110110, 25'hAB, 3'd5, 25'h77, BLK, 3'b000, 32'h0, Z);
    // clean read miss, memory busy 4 cycles
    add(6'b110001, 25'hAB, 3'd5, 25'h77, BLK, 3'b100, 32'h0, Z);
    for (int i = 0; i < 4; i++) add(6'b110001, 25'hAB, 3'd5, 25'h77, BLK, 3'b110, 32'h000055D0, Z);
    add(6'b110000, 25'hAB, 3'd5, 25'h77, BLK, 3'b110, 32'h000055D0, Z);
    add(6'b110100, 25'hAB, 3'd5, 25'h77, BLK, 3'b000, 32'h0, Z);
    // dirty write miss: write-back then fetch
    add(6'b101011, 25'h34, 3'd2, 25'h12, BLK, 3'b100, 32'h0, Z);
    add(6'b101011, 25'h34, 3'd2, 25'h12, BLK, 3'b101, 32'h00000920, BLK);
    add(6'b101011, 25'h34, 3'd2, 25'h12, BLK, 3'b101, 32'h00000920, BLK);
    add(6'b101010, 25'h34, 3'd2, 25'h12, BLK, 3'b101, 32'h00000920, BLK);
    add(6'b101011, 25'h34, 3'd2, 25'h12, BLK, 3'b110, 32'h00001A20, Z);
    add(6'b101010, 25'h34, 3'd2, 25'h12, BLK, 3'b110, 32'h00001A20, Z);
    add(6'b101110, 25'h34, 3'd2, 25'h12, BLK, 3'b000, 32'h0, Z);
    add(6'b100000, 25'h0, 3'd0, 25'h0, Z, 3'b000, 32'h0, Z);
    foreach (tv[i]) begin
      {reset, read, write, hit, dirty, mem_BusyWait} = tv[i].in_f;
      Tag = tv[i].tag; Index = tv[i].idx; Tag1 = tv[i].tag1; writedata1 = tv[i].wd1;
      @(negedge clock);
      cmp_all($sformatf("vec%0d", i), tv[i].exp_f, tv[i].e_addr, tv[i].e_wd);
      @(posedge clock); #1;
    end

    // reset during write-back with memory still busy
    reset = 1'b1; read = 1'b0; write = 1'b1; hit = 1'b0; dirty = 1'b1; mem_BusyWait = 1'b1;
    Tag1 = 25'h12; Tag = 25'h34; Index = 3'd2; writedata1 = BLK;
    @(posedge clock); #1;
    @(negedge clock);
    check("wb_before_reset mem_Write", 128'(mem_Write), 128'(1'b1));
    reset = 1'b0;
    @(posedge clock); #1;
    write = 1'b0; reset = 1'b1;
    @(negedge clock);
    cmp_all("reset_in_wb", 3'b000, 32'h0, Z);
    @(posedge clock); #1;

    // fast memory: busy never asserted, inputs change mid-transfer
    mem_BusyWait = 1'b0; read = 1'b1; hit = 1'b0; dirty = 1'b0; Tag = 25'hAB; Index = 3'd5;
    @(posedge clock); #1;
    read = 1'b0; Tag = 25'h1FFFFFF; Index = 3'd7;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (mem_Read) begin
        hi++;
        check("fast mem_Address", 128'(mem_Address), 128'(32'h000055D0));
      end
      @(posedge clock); #1;
    end
    check("fast mem_Read cycles", 128'(hi), 128'(2));
    @(negedge clock);
    cmp_all("fast_idle", 3'b000, 32'h0, Z);

    // randomized traffic against the reference model
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    model_edge();
    reset = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] ef;
      logic [31:0] ea;
      logic [127:0] ed;
      reset = ($urandom_range(0, 59) != 0);
      read = 1'($urandom_range(0, 1));
      write = 1'($urandom_range(0, 1));
      hit = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      mem_BusyWait = ($urandom_range(0, 2) != 0);
      Tag = 25'($urandom); Tag1 = 25'($urandom); Index = 3'($urandom);
      writedata1 = {$urandom, $urandom, $urandom, $urandom};
      address = $urandom; writedata = 8'($urandom);
      if (mq.size() == 0) begin
        ef = {(read | write) & ~hit, 2'b00}; ea = 32'h0; ed = Z;
      end else begin
        ef = {1'b1, ~mq[0].wr, mq[0].wr}; ea = mq[0].addr; ed = mq[0].data;
      end
      @(negedge clock);
      cmp_all($sformatf("rand%0d", n), ef, ea, ed);
      @(posedge clock);
      model_edge();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
